// File: rtl/mips_mem_pkg.sv
// Shared types and widths for the MIPS data-memory responder.
//   state_t : responder FSM states (IDLE accepts, BUSY counts latency, RESP answers)
//   ADDR_W  : word-address width
//   DATA_W  : data word width
//   MASK_W  : byte-lane write-enable width
//   CNT_W   : latency counter width (LATENCY up to 15)
package mips_mem_pkg;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int MASK_W = 4;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/mips_dmem_responder_if.sv
// Data-port bus between the MIPS core (master) and the memory responder (slave).
//   mem_req      : request valid, held by the core until accepted
//   mem_addr     : word address
//   mem_data_in  : store data
//   mem_write_en : byte-lane mask, bit 3 = bits 31:24, all-zero means load
//   mem_ready    : responder can accept this cycle
//   mem_valid    : one-cycle response pulse
//   mem_data_out : load data, zero for stores and exceptions
//   mem_excpt    : address fell outside the RAM window
interface mips_dmem_responder_if;
  import mips_mem_pkg::*;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in;
  logic [MASK_W-1:0] mem_write_en;
  logic              mem_ready;
  logic              mem_valid;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_excpt;

  modport master (
    output mem_req, mem_addr, mem_data_in, mem_write_en,
    input  mem_ready, mem_valid, mem_data_out, mem_excpt
  );

  modport slave (
    input  mem_req, mem_addr, mem_data_in, mem_write_en,
    output mem_ready, mem_valid, mem_data_out, mem_excpt
  );

endinterface

// File: rtl/mips_byte_ram.sv
// Single-port word RAM with byte-lane write enables and a registered read.
//   clk   : clock
//   en    : perform an access this edge
//   we    : byte-lane write mask; all-zero makes the access a read
//   addr  : word index
//   wdata : store data
//   rdata : read data, updated only on read accesses
module mips_byte_ram
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic              clk,
  input  logic              en,
  input  logic [MASK_W-1:0] we,
  input  logic [IDX_W-1:0]  addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // NOTE: the array and its read register carry no reset; clearing a RAM
  // would need a per-word loop that cannot map onto a block memory.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we == '0) begin
        rdata <= mem[addr];
      end else begin
        for (int lane = 0; lane < MASK_W; lane++) begin
          if (we[lane]) mem[addr][8*lane +: 8] <= wdata[8*lane +: 8];
        end
      end
    end
  end

endmodule

// File: rtl/mips_dmem_responder.sv
// Stallable data-memory responder for the MIPS core's data port.
// Accepts one load/store at a time, performs it against mips_byte_ram and
// raises mem_valid for one cycle. The response state is entered on the
// LATENCY-th edge counting the accept edge as the first, so LATENCY=1 answers
// straight off the accept edge and a new request can be taken every
// LATENCY+1 cycles.
//   clk  : clock, all state changes on the rising edge
//   rst  : synchronous active-high reset
//   bus  : slave side of mips_dmem_responder_if
module mips_dmem_responder
  import mips_mem_pkg::*;
#(
  parameter int                DEPTH_WORDS = 1024,
  parameter logic [ADDR_W-1:0] BASE_WADDR  = 30'h04000000,
  parameter int                LATENCY     = 2
) (
  input logic                  clk,
  input logic                  rst,
  mips_dmem_responder_if.slave bus
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              ready_q;
  logic              valid_q;
  logic              excpt_q;
  logic              load_hit_q;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic [MASK_W-1:0] mask_q;

  logic              accept;
  logic              enter_resp;
  logic              in_range;
  logic [ADDR_W-1:0] cur_addr;
  logic [ADDR_W-1:0] offset;
  logic [DATA_W-1:0] cur_data;
  logic [MASK_W-1:0] cur_mask;
  logic [DATA_W-1:0] ram_rdata;

  always_comb begin
    accept = bus.mem_req && ready_q;
    // With LATENCY=1 the RAM access lands on the accept edge, before the
    // request registers hold anything, so the live bus fields are used
    // whenever the FSM is idle.
    if (state_q == IDLE) begin
      cur_addr = bus.mem_addr;
      cur_data = bus.mem_data_in;
      cur_mask = bus.mem_write_en;
    end else begin
      cur_addr = addr_q;
      cur_data = data_q;
      cur_mask = mask_q;
    end
    // Unsigned 30-bit subtraction: addresses below the base wrap to huge
    // offsets and so fail the same single comparison as those above the top.
    offset     = cur_addr - BASE_WADDR;
    in_range   = offset < ADDR_W'(DEPTH_WORDS);
    enter_resp = ((state_q == IDLE) && accept && (LATENCY == 1)) ||
                 ((state_q == BUSY) && (cnt_q == '0));
  end

  // NOTE: request holding registers need no reset; they are only consumed
  // after an accept has loaded them.
  always_ff @(posedge clk) begin
    if (accept && (state_q == IDLE)) begin
      addr_q <= bus.mem_addr;
      data_q <= bus.mem_data_in;
      mask_q <= bus.mem_write_en;
    end
  end

  // Reset on the edge that would enter RESP blocks the RAM access.
  mips_byte_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_ram (
    .clk   (clk),
    .en    (enter_resp && in_range && !rst),
    .we    (cur_mask),
    .addr  (offset[IDX_W-1:0]),
    .wdata (cur_data),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      excpt_q    <= 1'b0;
      load_hit_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            if (enter_resp) begin
              state_q    <= RESP;
              valid_q    <= 1'b1;
              excpt_q    <= !in_range;
              load_hit_q <= in_range && (cur_mask == '0);
            end else begin
              state_q <= BUSY;
              cnt_q   <= CNT_W'(LATENCY - 2);
            end
          end
        end
        BUSY: begin
          if (enter_resp) begin
            state_q    <= RESP;
            valid_q    <= 1'b1;
            excpt_q    <= !in_range;
            load_hit_q <= in_range && (cur_mask == '0);
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESP: begin
          state_q    <= IDLE;
          ready_q    <= 1'b1;
          valid_q    <= 1'b0;
          excpt_q    <= 1'b0;
          load_hit_q <= 1'b0;
        end
        default: begin
          state_q    <= IDLE;
          ready_q    <= 1'b1;
          valid_q    <= 1'b0;
          excpt_q    <= 1'b0;
          load_hit_q <= 1'b0;
        end
      endcase
    end
  end

  // The RAM read register keeps its last value; the registered load flag
  // zeroes it outside a load response.
  assign bus.mem_ready    = ready_q;
  assign bus.mem_valid    = valid_q;
  assign bus.mem_excpt    = excpt_q;
  assign bus.mem_data_out = load_hit_q ? ram_rdata : '0;

endmodule

// File: tb/tb_mips_dmem_responder.sv
// Directed plus randomized bench for mips_dmem_responder; one instance at
// LATENCY=2 carries most of the traffic, a second at LATENCY=1 checks the
// shortest response path. Expected data comes from a sparse word model.
module tb_mips_dmem_responder;
  import mips_mem_pkg::*;

  localparam logic [29:0] BASE  = 30'h04000000;
  localparam int          DEPTH = 1024;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mips_dmem_responder_if bus ();
  mips_dmem_responder_if bus1 ();

  mips_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_WADDR(BASE), .LATENCY(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  mips_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_WADDR(BASE), .LATENCY(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] model [longint];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: window test on plain signed arithmetic, masked
  // merge byte by byte, store committed to the model immediately.
  task automatic predict(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m,
                         output logic [31:0] rdata, output logic exc);
    longint      off;
    logic [31:0] w;
    off = longint'(a) - longint'(BASE);
    if (off < 0 || off >= DEPTH) begin
      exc   = 1'b1;
      rdata = 32'h0;
    end else if (m == 4'h0) begin
      exc   = 1'b0;
      rdata = model.exists(off) ? model[off] : 'x;
    end else begin
      w = model.exists(off) ? model[off] : 'x;
      for (int i = 0; i < 4; i++) if (m[i]) w[8*i +: 8] = d[8*i +: 8];
      model[off] = w;
      exc   = 1'b0;
      rdata = 32'h0;
    end
  endtask

  // One full transaction on the LATENCY=2 instance, entered and left at #1
  // after an edge with the responder idle.
  task automatic issue(input logic [29:0] a, input logic [31:0] d, input logic [3:0] m,
                       input string tag);
    logic [31:0] er;
    logic        ex;
    check({tag, "_ready_pre"}, 32'(bus.mem_ready), 32'd1);
    predict(a, d, m, er, ex);
    bus.mem_req      = 1'b1;
    bus.mem_addr     = a;
    bus.mem_data_in  = d;
    bus.mem_write_en = m;
    @(posedge clk); #1;
    bus.mem_req = 1'b0;
    check({tag, "_valid_early"}, 32'(bus.mem_valid), 32'd0);
    check({tag, "_ready_busy"}, 32'(bus.mem_ready), 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid"}, 32'(bus.mem_valid), 32'd1);
    check({tag, "_data"}, bus.mem_data_out, er);
    check({tag, "_excpt"}, 32'(bus.mem_excpt), 32'(ex));
    check({tag, "_ready_resp"}, 32'(bus.mem_ready), 32'd0);
    @(posedge clk); #1;
    check({tag, "_valid_end"}, 32'(bus.mem_valid), 32'd0);
    check({tag, "_ready_end"}, 32'(bus.mem_ready), 32'd1);
    check({tag, "_data_end"}, bus.mem_data_out, 32'h0);
    check({tag, "_excpt_end"}, 32'(bus.mem_excpt), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] er;
    logic        ex;
    logic [29:0] a;
    logic [3:0]  m;

    bus.mem_req  = 1'b0; bus.mem_addr  = '0; bus.mem_data_in  = '0; bus.mem_write_en  = '0;
    bus1.mem_req = 1'b0; bus1.mem_addr = '0; bus1.mem_data_in = '0; bus1.mem_write_en = '0;

    // Reset values
    @(posedge clk); #1;
    check("rst_ready", 32'(bus.mem_ready), 32'd1);
    check("rst_valid", 32'(bus.mem_valid), 32'd0);
    check("rst_data", bus.mem_data_out, 32'h0);
    check("rst_excpt", 32'(bus.mem_excpt), 32'd0);
    check("rst_ready1", 32'(bus1.mem_ready), 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // Idle with no requests
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("idle_ready", 32'(bus.mem_ready), 32'd1);
      check("idle_valid", 32'(bus.mem_valid), 32'd0);
      check("idle_data", bus.mem_data_out, 32'h0);
      check("idle_excpt", 32'(bus.mem_excpt), 32'd0);
    end

    // Full-word store/load, then a single-lane overwrite
    issue(BASE + 30'h10, 32'hDEADBEEF, 4'hF, "st_full");
    issue(BASE + 30'h10, 32'h0, 4'h0, "ld_full");
    issue(BASE + 30'h10, 32'h000000AA, 4'b0001, "st_lane0");
    issue(BASE + 30'h10, 32'h0, 4'h0, "ld_lane0");

    // Window edges
    issue(30'h03FFFFFF, 32'h0, 4'h0, "ld_below");
    issue(BASE + 30'd1023, 32'h5A5A5A5A, 4'hF, "st_top");
    issue(BASE + 30'd1024, 32'hFFFFFFFF, 4'hF, "st_above");
    issue(BASE + 30'd1023, 32'h0, 4'h0, "ld_top");
    issue(BASE, 32'h01020304, 4'hF, "st_base");
    issue(BASE, 32'h0, 4'h0, "ld_base");

    // mem_req held high: accepts three edges apart, ready only in IDLE
    predict(BASE + 30'h10, 32'h0, 4'h0, er, ex);
    bus.mem_req = 1'b1; bus.mem_addr = BASE + 30'h10; bus.mem_write_en = 4'h0;
    for (int k = 0; k < 9; k++) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(bus.mem_valid), 32'((k % 3) == 1));
      check("hold_ready", 32'(bus.mem_ready), 32'((k % 3) == 2));
      if (bus.mem_valid) check("hold_data", bus.mem_data_out, er);
    end
    bus.mem_req = 1'b0;

    // Reset during BUSY, on the edge that would enter RESP: store dropped
    bus.mem_req = 1'b1; bus.mem_addr = BASE + 30'h10;
    bus.mem_data_in = 32'h12345678; bus.mem_write_en = 4'hF;
    @(posedge clk); #1;
    bus.mem_req = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    check("abort_valid", 32'(bus.mem_valid), 32'd0);
    check("abort_ready", 32'(bus.mem_ready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_idle_valid", 32'(bus.mem_valid), 32'd0);
    issue(BASE + 30'h10, 32'h0, 4'h0, "ld_after_abort");

    // Reset during RESP: store already committed, outputs clear
    predict(BASE + 30'h20, 32'h0BADF00D, 4'hF, er, ex);
    bus.mem_req = 1'b1; bus.mem_addr = BASE + 30'h20;
    bus.mem_data_in = 32'h0BADF00D; bus.mem_write_en = 4'hF;
    @(posedge clk); #1;
    bus.mem_req = 1'b0;
    @(posedge clk); #1;
    check("rresp_valid", 32'(bus.mem_valid), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rresp_valid_clr", 32'(bus.mem_valid), 32'd0);
    check("rresp_ready", 32'(bus.mem_ready), 32'd1);
    rst = 1'b0;
    issue(BASE + 30'h20, 32'h0, 4'h0, "ld_after_rresp");

    // Request alongside reset is not accepted
    rst = 1'b1; bus.mem_req = 1'b1; bus.mem_addr = BASE + 30'h10; bus.mem_write_en = 4'h0;
    @(posedge clk); #1;
    rst = 1'b0; bus.mem_req = 1'b0;
    check("rstreq_ready", 32'(bus.mem_ready), 32'd1);
    @(posedge clk); #1;
    check("rstreq_valid", 32'(bus.mem_valid), 32'd0);
    check("rstreq_ready2", 32'(bus.mem_ready), 32'd1);

    // Randomized traffic over 16 words plus out-of-window addresses
    for (int i = 0; i < 16; i++) issue(BASE + 30'(i), $urandom, 4'hF, "rnd_init");
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0:       a = BASE - 30'($urandom_range(1, 100));
        1:       a = BASE + 30'(DEPTH) + 30'($urandom_range(0, 100));
        2:       a = 30'($urandom);
        default: a = BASE + 30'($urandom_range(0, 15));
      endcase
      m = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      issue(a, $urandom, m, "rnd");
    end

    // LATENCY=1: response directly after the accept edge
    bus1.mem_req = 1'b1; bus1.mem_addr = BASE + 30'd5;
    bus1.mem_data_in = 32'hCAFEF00D; bus1.mem_write_en = 4'hF;
    @(posedge clk); #1;
    bus1.mem_req = 1'b0;
    check("l1_st_valid", 32'(bus1.mem_valid), 32'd1);
    check("l1_st_data", bus1.mem_data_out, 32'h0);
    check("l1_st_ready", 32'(bus1.mem_ready), 32'd0);
    @(posedge clk); #1;
    check("l1_st_valid_end", 32'(bus1.mem_valid), 32'd0);
    check("l1_st_ready_end", 32'(bus1.mem_ready), 32'd1);
    bus1.mem_req = 1'b1; bus1.mem_write_en = 4'h0;
    @(posedge clk); #1;
    bus1.mem_req = 1'b0;
    check("l1_ld_valid", 32'(bus1.mem_valid), 32'd1);
    check("l1_ld_data", bus1.mem_data_out, 32'hCAFEF00D);
    check("l1_ld_excpt", 32'(bus1.mem_excpt), 32'd0);
    @(posedge clk); #1;
    bus1.mem_req = 1'b1; bus1.mem_addr = BASE - 30'd1;
    @(posedge clk); #1;
    bus1.mem_req = 1'b0;
    check("l1_exc_valid", 32'(bus1.mem_valid), 32'd1);
    check("l1_exc_excpt", 32'(bus1.mem_excpt), 32'd1);
    check("l1_exc_data", bus1.mem_data_out, 32'h0);
    @(posedge clk); #1;
    check("l1_exc_clr", 32'(bus1.mem_excpt), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
